mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the fetch stage (instruction reads) and the execute/mem stage (data loads/stores).
- Data requests have priority, with a starvation limit that forces a fetch grant.
- Each requester sees a hold-request / one-cycle-valid handshake; the block drives a pipeline stall while any request is unserviced.

Parameters:
- ADDR_W, 32, address width on both requester ports and the memory port.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, max consecutive data grants while a fetch request is pending; range 1..15.
- TIMEOUT_CYCLES, 64, busy cycles without ack before abort (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_if_req  in  1  fetch request, held until o_if_valid
- i_if_addr  in  ADDR_W  fetch address
- o_if_rdata  out  DATA_W  fetched instruction, valid with o_if_valid
- o_if_valid  out  1  one-cycle completion pulse
- i_d_req  in  1  data request, held until o_d_valid
- i_d_we  in  1  1=store, 0=load
- i_d_addr  in  ADDR_W  data address
- i_d_wdata  in  DATA_W  store data
- o_d_rdata  out  DATA_W  load data
- o_d_valid  out  1  one-cycle completion pulse (loads and stores)
- o_stall  out  1  pipeline stall
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_ack  in  1  memory completion, one cycle
- i_mem_rdata  in  DATA_W  read data, valid with i_mem_ack
- o_err  out  1  sticky timeout error

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous, active-high. On reset all outputs are 0, the FSM goes to IDLE and the starve counter clears.
- FSM states: IDLE, IF_BUSY, D_BUSY.
- Arbitration in IDLE, when any request is present:
  - Grant IF if i_if_req and (!i_d_req or starve_cnt==STARVE_LIMIT).
  - Otherwise grant D.
- On a grant, register o_mem_req=1 and o_mem_addr/o_mem_we/o_mem_wdata from the granted port; o_mem_we=0 for IF. Enter the matching BUSY state.
- In BUSY: memory outputs are held stable until i_mem_ack. On ack:
  - Drop o_mem_req.
  - Register i_mem_rdata into the granted port's rdata. A store leaves o_d_rdata unchanged.
  - Pulse that port's valid for exactly one cycle.
  - Return to IDLE.
- Latency: request sampled in IDLE at cycle N → o_mem_req high at N+1 → earliest ack at N+1 → valid at N+2. Minimum 2 cycles per access, one IDLE cycle between accesses.
- Starve counter:
  - Increments on a D grant made while i_if_req=1.
  - Clears on an IF grant, or on a D grant with i_if_req=0.
  - Saturates at STARVE_LIMIT.
- o_stall (combinational) = (i_if_req & !o_if_valid) | (i_d_req & !o_d_valid).
- Requester drops its req mid-transaction: the transaction still completes and valid still pulses. Requesters must ignore the stray pulse.
- i_mem_ack in IDLE is ignored: no valid pulse, no state change.
- Simultaneous new requests while BUSY are not sampled until IDLE.
- Reset asserted mid-transaction: o_mem_req drops immediately (async), any in-flight access is discarded, and a late ack after reset is ignored.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in the BUSY states.
  - When it reaches TIMEOUT_CYCLES with no ack: drop o_mem_req, pulse the granted port's valid with rdata=32'hDEAD_BEEF, set o_err (sticky until i_rst), and return to IDLE.
  - The counter clears on every grant.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - o_err tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, IF_BUSY, D_BUSY}.
  - typedef enum grant_e {GNT_IF, GNT_D}.
  - localparam ERR_RDATA=32'hDEAD_BEEF.
- One sub-module, mem_arb_prio: the combinational grant decision plus the starve counter. Its outputs are grant_e and grant_valid.

Test Plan:
- Single fetch: i_if_req=1, addr 0x100, ack 3 cycles after o_mem_req with rdata 0x2002_0005 → o_if_valid pulses once with o_if_rdata=0x2002_0005; o_stall high until that cycle.
- Simultaneous requests: IF 0x104 and D load 0x400 in the same cycle → D granted first (o_mem_addr=0x400, we=0), IF granted after o_d_valid.
- Starvation: i_if_req held while D requests back-to-back with STARVE_LIMIT=4 → exactly 4 D grants, then the 5th grant goes to IF at 0x108.
- Store: d_we=1, addr 0x40C, wdata 0xCAFE_F00D → o_mem_we=1 with that data held stable through a 5-cycle ack delay; o_d_valid pulses and o_d_rdata is unchanged.
- Reset mid-access: assert i_rst during D_BUSY → o_mem_req goes 0 the same cycle; an ack two cycles after reset release produces no valid pulse.
- Timeout (macro on, TIMEOUT_CYCLES=64): never ack → at busy cycle 64 o_mem_req drops, valid pulses with rdata 0xDEAD_BEEF, and o_err=1 until reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and constants for the memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

  // Read data returned to a requester whose access was abandoned by the watchdog.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Starve counter width; covers the legal STARVE_LIMIT range of 1..15.
  localparam int STARVE_W = 4;

  // Saturating increment that stops at the given limit.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                  input logic [STARVE_W-1:0] limit);
    return (cnt == limit) ? cnt : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: grant decision between fetch and data requesters, with a
// starvation counter that forces a fetch grant after STARVE_LIMIT data grants
// made while a fetch was waiting.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   if_req,
  input  logic   d_req,
  output grant_e grant,
  output logic   grant_valid
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arb_prio: STARVE_LIMIT must be within 1..15");
  end

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;

  // Data wins by default; a fetch that has waited through LIMIT data grants takes the next slot.
  always_comb begin
    starved     = (starve_cnt == LIMIT);
    grant_valid = arb_en & (if_req | d_req);
    grant       = GNT_D;
    if (if_req && (!d_req || starved)) begin
      grant = GNT_IF;
    end
  end

  // Count data grants made over a waiting fetch; any other grant ends the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_valid) begin
      if (grant == GNT_D && if_req) begin
        starve_cnt <= sat_inc(starve_cnt, LIMIT);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// fetch stage and the data stage. Data has priority, bounded by a starvation
// limit. Each access is registered onto the memory port in IDLE and held until
// the memory acks; the requester then sees a one-cycle valid pulse.
// A requester that wants back-to-back service replaces its request (or drops
// it) in the cycle its valid pulse is visible.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort accesses that see no
// ack within TIMEOUT_CYCLES busy cycles (returns ERR_RDATA, sets sticky o_err).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e        state_q;
  arb_state_e        state_d;
  grant_e            grant;
  logic              grant_valid;

  logic              mem_req_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_d;
  logic [DATA_W-1:0] d_rdata_d;
  logic              if_valid_d;
  logic              d_valid_d;
  logic              done;
  logic              aborted;
  logic [DATA_W-1:0] done_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_d;
  logic             err_d;
`else
  assign o_err = 1'b0;
`endif

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk         (i_clk),
    .rst         (i_rst),
    .arb_en      (state_q == IDLE),
    .if_req      (i_if_req),
    .d_req       (i_d_req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // The pipeline stalls while either stage has a request not yet answered this cycle.
  assign o_stall = (i_if_req & ~o_if_valid) | (i_d_req & ~o_d_valid);

  // Next-state and next-output logic: launch on grant in IDLE, complete on ack (or watchdog) in BUSY.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = o_mem_req;
    mem_we_d    = o_mem_we;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    if_rdata_d  = o_if_rdata;
    d_rdata_d   = o_d_rdata;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;
    done_data   = i_mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d       = tmo_cnt;
    err_d       = o_err;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
          if (grant == GNT_IF) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            state_d     = IF_BUSY;
          end else begin
            mem_we_d    = i_d_we;
            mem_addr_d  = i_d_addr;
            mem_wdata_d = i_d_wdata;
            state_d     = D_BUSY;
          end
        end
      end

      IF_BUSY, D_BUSY: begin
        if (i_mem_ack) begin
          done = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          done      = 1'b1;
          aborted   = 1'b1;
          done_data = DATA_W'(ERR_RDATA);
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
`endif
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == IF_BUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = done_data;
          end else begin
            d_valid_d = 1'b1;
            if (!o_mem_we || aborted) begin
              d_rdata_d = done_data;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_rdata  <= '0;
      o_d_rdata   <= '0;
      o_if_valid  <= 1'b0;
      o_d_valid   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
      o_err       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      o_mem_req   <= mem_req_d;
      o_mem_we    <= mem_we_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
      o_if_rdata  <= if_rdata_d;
      o_d_rdata   <= d_rdata_d;
      o_if_valid  <= if_valid_d;
      o_d_valid   <= d_valid_d;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt     <= tmo_d;
      o_err       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives fetch/data requesters and a memory responder cycle by
// cycle, predicting every output from a transaction-level arbitration model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 64;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_valid;
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_d_valid;
  logic              o_stall;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_err;

  mem_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .STARVE_LIMIT   (STARVE_LIMIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_rdata  (o_if_rdata),
    .o_if_valid  (o_if_valid),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_rdata   (o_d_rdata),
    .o_d_valid   (o_d_valid),
    .o_stall     (o_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_err       (o_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } d_op_t;

  int tests_run    = 0;
  int tests_failed = 0;

  // Requester plans and state
  logic [31:0] if_q[$];
  d_op_t       d_q[$];
  logic [31:0] rdata_q[$];
  logic        if_active;
  logic [31:0] if_cur;
  logic        d_active;
  d_op_t       d_cur;
  int          ack_delay;
  bit          gap_mode;
  bit          stray_ack;
  bit          force_ack;
  int          busy_cycles;

  // Observations
  logic [31:0] dut_grants[$];
  logic        prev_mem_req;
  int          if_valid_seen;
  int          d_valid_seen;

  // Reference model
  bit          m_busy;
  bit          m_owner_d;
  int          m_starve;
`ifdef MEM_ARB_TIMEOUT_EN
  int          m_tcnt;
`endif
  logic        exp_mem_req;
  logic        exp_mem_we;
  logic [31:0] exp_mem_addr;
  logic [31:0] exp_mem_wdata;
  logic        exp_if_valid;
  logic        exp_d_valid;
  logic        exp_err;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic        exp_stall;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic failBound(input string tag, input int cycles);
    tests_run++;
    tests_failed++;
    $error("[TB] FAIL %s: still busy after %0d cycles, expected idle", tag, cycles);
  endtask

  function automatic logic [31:0] grantAt(input int idx);
    if (idx < dut_grants.size()) return dut_grants[idx];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic modelReset();
    m_busy        = 1'b0;
    m_owner_d     = 1'b0;
    m_starve      = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    m_tcnt        = 0;
`endif
    exp_mem_req   = 1'b0;
    exp_mem_we    = 1'b0;
    exp_mem_addr  = 32'h0;
    exp_mem_wdata = 32'h0;
    exp_if_valid  = 1'b0;
    exp_d_valid   = 1'b0;
    exp_err       = 1'b0;
    exp_if_rdata  = 32'h0;
    exp_d_rdata   = 32'h0;
  endtask

  task automatic requestersIdle();
    if_active   = 1'b0;
    d_active    = 1'b0;
    if_cur      = 32'h0;
    d_cur       = '0;
    busy_cycles = 0;
    force_ack   = 1'b0;
    i_if_req    = 1'b0;
    i_if_addr   = 32'h0;
    i_d_req     = 1'b0;
    i_d_we      = 1'b0;
    i_d_addr    = 32'h0;
    i_d_wdata   = 32'h0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'h0;
  endtask

  task automatic clearLog();
    dut_grants.delete();
    if_valid_seen = 0;
    d_valid_seen  = 0;
  endtask

  task automatic modelFinish(input logic [31:0] data, input bit abort);
    exp_mem_req = 1'b0;
    m_busy      = 1'b0;
    if (m_owner_d) begin
      exp_d_valid = 1'b1;
      if (!exp_mem_we || abort) exp_d_rdata = data;
    end else begin
      exp_if_valid = 1'b1;
      exp_if_rdata = data;
    end
    if (abort) exp_err = 1'b1;
  endtask

  // Predict the outputs after the next clock edge from the inputs now driven.
  task automatic modelUpdate();
    bit take_if;
    exp_if_valid = 1'b0;
    exp_d_valid  = 1'b0;
    if (!m_busy) begin
      if (i_if_req || i_d_req) begin
        take_if = i_if_req && (!i_d_req || m_starve == STARVE_LIMIT);
        if (take_if) begin
          m_starve     = 0;
          m_owner_d    = 1'b0;
          exp_mem_we   = 1'b0;
          exp_mem_addr = i_if_addr;
        end else begin
          m_starve      = i_if_req ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
          m_owner_d     = 1'b1;
          exp_mem_we    = i_d_we;
          exp_mem_addr  = i_d_addr;
          exp_mem_wdata = i_d_wdata;
        end
        m_busy      = 1'b1;
        exp_mem_req = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        m_tcnt      = 0;
`endif
      end
    end else if (i_mem_ack) begin
      modelFinish(i_mem_rdata, 1'b0);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    else begin
      m_tcnt++;
      if (m_tcnt == TIMEOUT_CYCLES) modelFinish(ERR_RDATA, 1'b1);
    end
`endif
  endtask

  // One clock cycle: check registered outputs, react as requesters/memory, check stall, advance model.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    checkOutput("mem_req", 32'(o_mem_req), 32'(exp_mem_req));
    if (exp_mem_req) begin
      checkOutput("mem_we", 32'(o_mem_we), 32'(exp_mem_we));
      checkOutput("mem_addr", o_mem_addr, exp_mem_addr);
      if (exp_mem_we) checkOutput("mem_wdata", o_mem_wdata, exp_mem_wdata);
    end
    checkOutput("if_valid", 32'(o_if_valid), 32'(exp_if_valid));
    checkOutput("d_valid", 32'(o_d_valid), 32'(exp_d_valid));
    checkOutput("if_rdata", o_if_rdata, exp_if_rdata);
    checkOutput("d_rdata", o_d_rdata, exp_d_rdata);
    checkOutput("err", 32'(o_err), 32'(exp_err));

    if (o_mem_req && !prev_mem_req) dut_grants.push_back(o_mem_addr);
    prev_mem_req = o_mem_req;
    if (o_if_valid) if_valid_seen++;
    if (o_d_valid) d_valid_seen++;

    if (exp_if_valid) if_active = 1'b0;
    if (exp_d_valid) d_active = 1'b0;
    if (!if_active && if_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 0)) begin
      if_cur    = if_q.pop_front();
      if_active = 1'b1;
    end
    if (!d_active && d_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 0)) begin
      d_cur    = d_q.pop_front();
      d_active = 1'b1;
    end
    i_if_req  = if_active;
    i_if_addr = if_active ? if_cur : 32'h0;
    i_d_req   = d_active;
    i_d_we    = d_active ? d_cur.we : 1'b0;
    i_d_addr  = d_active ? d_cur.addr : 32'h0;
    i_d_wdata = d_active ? d_cur.wdata : 32'h0;

    if (exp_mem_req) busy_cycles++;
    else busy_cycles = 0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom();
    if (exp_mem_req) begin
      if (ack_delay < 0) i_mem_ack = ($urandom_range(0, 2) == 0);
      else if (ack_delay > 0) i_mem_ack = (busy_cycles == ack_delay);
      if (i_mem_ack && rdata_q.size() > 0) i_mem_rdata = rdata_q.pop_front();
    end else if (stray_ack) begin
      i_mem_ack = ($urandom_range(0, 7) == 0);
    end
    if (force_ack) i_mem_ack = 1'b1;

    #1;
    exp_stall = (i_if_req & ~exp_if_valid) | (i_d_req & ~exp_d_valid);
    checkOutput("stall", 32'(o_stall), 32'(exp_stall));
    modelUpdate();
  endtask

  task automatic runUntilIdle(input int max_cycles, input string tag);
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < max_cycles) begin
      applyStimulus();
      n++;
      idle = (if_q.size() == 0) && (d_q.size() == 0) && !if_active && !d_active && !m_busy;
    end
    if (!idle) failBound(tag, n);
  endtask

  initial begin
    logic [31:0] starve_exp[7];
    d_op_t       op;

    i_rst        = 1'b1;
    ack_delay    = 1;
    gap_mode     = 1'b0;
    stray_ack    = 1'b0;
    prev_mem_req = 1'b0;
    requestersIdle();
    modelReset();
    clearLog();

    // Reset state
    #1;
    checkOutput("rst_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("rst_mem_addr", o_mem_addr, 32'd0);
    checkOutput("rst_if_valid", 32'(o_if_valid), 32'd0);
    checkOutput("rst_d_valid", 32'(o_d_valid), 32'd0);
    checkOutput("rst_if_rdata", o_if_rdata, 32'd0);
    checkOutput("rst_d_rdata", o_d_rdata, 32'd0);
    checkOutput("rst_stall", 32'(o_stall), 32'd0);
    checkOutput("rst_err", 32'(o_err), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Single fetch, ack in the fourth cycle of o_mem_req
    clearLog();
    if_q.push_back(32'h0000_0100);
    rdata_q.push_back(32'h2002_0005);
    ack_delay = 4;
    runUntilIdle(40, "t1_bound");
    checkOutput("t1_grants", 32'(dut_grants.size()), 32'd1);
    checkOutput("t1_grant0", grantAt(0), 32'h0000_0100);
    checkOutput("t1_if_pulses", 32'(if_valid_seen), 32'd1);
    checkOutput("t1_if_rdata", o_if_rdata, 32'h2002_0005);

    // Simultaneous fetch and data load: data first
    clearLog();
    if_q.push_back(32'h0000_0104);
    op = '{we: 1'b0, addr: 32'h0000_0400, wdata: 32'h0};
    d_q.push_back(op);
    ack_delay = 1;
    runUntilIdle(40, "t2_bound");
    checkOutput("t2_grant0", grantAt(0), 32'h0000_0400);
    checkOutput("t2_grant1", grantAt(1), 32'h0000_0104);
    checkOutput("t2_d_pulses", 32'(d_valid_seen), 32'd1);
    checkOutput("t2_if_pulses", 32'(if_valid_seen), 32'd1);

    // Starvation: fetch held while six data loads arrive back to back
    clearLog();
    if_q.push_back(32'h0000_0108);
    for (int i = 0; i < 6; i++) begin
      op = '{we: 1'b0, addr: 32'h0000_0500 + 32'(4 * i), wdata: 32'h0};
      d_q.push_back(op);
    end
    for (int i = 0; i < 7; i++) rdata_q.push_back(32'h1000_0000 + 32'(i));
    starve_exp = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h108, 32'h510, 32'h514};
    ack_delay = 2;
    runUntilIdle(100, "t3_bound");
    checkOutput("t3_grants", 32'(dut_grants.size()), 32'd7);
    for (int i = 0; i < 7; i++) checkOutput($sformatf("t3_grant%0d", i), grantAt(i), starve_exp[i]);
    checkOutput("t3_if_rdata", o_if_rdata, 32'h1000_0004);

    // Store with a five-cycle ack delay leaves load data untouched
    clearLog();
    op = '{we: 1'b1, addr: 32'h0000_040C, wdata: 32'hCAFE_F00D};
    d_q.push_back(op);
    ack_delay = 5;
    runUntilIdle(40, "t4_bound");
    checkOutput("t4_grant0", grantAt(0), 32'h0000_040C);
    checkOutput("t4_d_pulses", 32'(d_valid_seen), 32'd1);
    checkOutput("t4_d_rdata", o_d_rdata, 32'h1000_0006);

    // Randomized traffic with random ack delays and stray acks while idle
    clearLog();
    for (int i = 0; i < 30; i++) begin
      if_q.push_back(32'($urandom_range(0, 1023)) << 2);
      op = '{we: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 1023)) << 2,
             wdata: $urandom()};
      d_q.push_back(op);
    end
    ack_delay = -1;
    gap_mode  = 1'b1;
    stray_ack = 1'b1;
    runUntilIdle(4000, "t5_bound");
    checkOutput("t5_if_pulses", 32'(if_valid_seen), 32'd30);
    checkOutput("t5_d_pulses", 32'(d_valid_seen), 32'd30);
    gap_mode  = 1'b0;
    stray_ack = 1'b0;

    // Reset during a data access, then a late ack
    clearLog();
    op = '{we: 1'b0, addr: 32'h0000_0600, wdata: 32'h0};
    d_q.push_back(op);
    ack_delay = 0;
    repeat (3) applyStimulus();
    checkOutput("t6_busy", 32'(o_mem_req), 32'd1);
    i_rst = 1'b1;
    #1;
    checkOutput("t6_async_mem_req", 32'(o_mem_req), 32'd0);
    d_q.delete();
    requestersIdle();
    modelReset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst        = 1'b0;
    prev_mem_req = 1'b0;
    clearLog();
    applyStimulus();
    force_ack = 1'b1;
    applyStimulus();
    force_ack = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("t6_d_pulses", 32'(d_valid_seen), 32'd0);
    checkOutput("t6_grants", 32'(dut_grants.size()), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: a fetch that is never acked
    clearLog();
    if_q.push_back(32'h0000_0700);
    ack_delay = 0;
    runUntilIdle(200, "t7_bound");
    checkOutput("t7_if_pulses", 32'(if_valid_seen), 32'd1);
    checkOutput("t7_if_rdata", o_if_rdata, 32'hDEAD_BEEF);
    repeat (3) applyStimulus();
    checkOutput("t7_err_sticky", 32'(o_err), 32'd1);
    i_rst = 1'b1;
    #1;
    checkOutput("t7_err_cleared", 32'(o_err), 32'd0);
    requestersIdle();
    modelReset();
    @(negedge i_clk);
    i_rst = 1'b0;
`else
    checkOutput("err_tied_low", 32'(o_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
